operand_loader: RTL and testbench

Upstream feeder for the scheduled-datapath controller. It collects one job's input operands from a serial valid/ready stream into the operand register bank that the datapath's functional-unit input multiplexers read from. It issues a one-cycle `start` when the controller reports `op_ready`. It holds the operands stable until the controller signals `done_next`, then reopens for the next job.

---
 rtl/operand_loader_if.sv | 35 +++
 rtl/operand_loader.sv | 112 +++++++++++
 tb/tb_operand_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader_if
//  Description : Bundle of the operand_loader's stream, controller and status
//                signals. The slave side is the loader itself; the master
//                side is whoever feeds words and plays the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_loader_if #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 8
);
    logic                       in_valid;
    logic [DATA_W-1:0]          in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       op_ready;
    logic                       done_next;
    logic                       start;
    logic [NUM_IN*DATA_W-1:0]   ops;
    logic                       busy;
    logic                       err_len;
    logic [15:0]                job_cnt;

    modport master (
        output in_valid, in_data, in_last, op_ready, done_next,
        input  in_ready, start, ops, busy, err_len, job_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, op_ready, done_next,
        output in_ready, start, ops, busy, err_len, job_cnt
    );
endinterface
`default_nettype wire

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader
//  Description : Collects one job's operands from a valid/ready word stream
//                into a register bank, launches the controller with a
//                one-cycle start, and holds the bank until the job completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 8,
    parameter int CNT_W  = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    operand_loader_if.slave     bus
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FULL  = 2'd1,
        S_ISSUE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(NUM_IN - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_slot [NUM_IN];
    logic [15:0]         r_job_cnt;
    logic                r_err_len;

    logic                w_in_ready;
    logic                w_hs;
    logic                w_at_last;

    // Ready is a pure state decode, forced low while reset is held.
    assign w_in_ready = (r_state == S_LOAD) && !rst;
    assign w_hs       = bus.in_valid && w_in_ready;
    assign w_at_last  = (r_cnt == c_last_slot);

    // Job sequencing, operand capture, length checking and job counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_job_cnt <= '0;
            r_err_len <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_hs) begin
                        // Write the current slot; a short job also zeroes
                        // every slot above it so stale operands never leak.
                        for (int i = 0; i < NUM_IN; i++) begin
                            if (CNT_W'(i) == r_cnt) begin
                                r_slot[i] <= bus.in_data;
                            end else if (bus.in_last && (CNT_W'(i) > r_cnt)) begin
                                r_slot[i] <= '0;
                            end
                        end
                        if (bus.in_last || w_at_last) begin
                            // Exactly-right length is last word on last slot.
                            r_err_len <= (bus.in_last != w_at_last);
                            r_cnt     <= '0;
                            r_state   <= S_FULL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.op_ready) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.done_next) begin
                        r_job_cnt <= r_job_cnt + 16'd1;
                        r_state   <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Flatten the slot array onto the operand bus, slot i at [i*DATA_W +: DATA_W].
    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_ops
            assign bus.ops[g*DATA_W +: DATA_W] = r_slot[g];
        end
    endgenerate

    assign bus.in_ready = w_in_ready;
    assign bus.start    = (r_state == S_ISSUE);
    assign bus.busy     = (r_state != S_LOAD);
    assign bus.err_len  = r_err_len;
    assign bus.job_cnt  = r_job_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_loader
//  Description : Self-checking bench for operand_loader: directed job table,
//                hand-written corner sequences and randomized jobs checked
//                against a slot-array model of the expected operand bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

    localparam int DATA_W = 16;
    localparam int NUM_IN = 8;
    localparam int BANK_W = DATA_W * NUM_IN;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_err    = 0;
    int exp_jobs = 0;

    operand_loader_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) bus ();

    operand_loader #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .CNT_W  (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.start === 1'b1)   n_start = n_start + 1;
        if (bus.err_len === 1'b1) n_err   = n_err + 1;
    end

    typedef struct {
        string              name;
        int                 n;
        bit                 last;
        logic [BANK_W-1:0]  words;
        int                 delay;
        logic [BANK_W-1:0]  exp_ops;
        bit                 exp_err;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string nm, input logic [BANK_W-1:0] act,
                         input logic [BANK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bank: the job's words in order, zeros above the job length.
    function automatic logic [BANK_W-1:0] model_ops(input logic [BANK_W-1:0] wp,
                                                     input int n);
        logic [BANK_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i < n) r[i*DATA_W +: DATA_W] = wp[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    task automatic send_word(input logic [DATA_W-1:0] d, input bit last, input bit gaps);
        int t;
        if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL hs_timeout: got in_ready=0 required in_ready=1");
        end
        step();
    endtask

    task automatic run_job(input string nm, input int n, input bit last,
                           input logic [BANK_W-1:0] wp, input int delay,
                           input logic [BANK_W-1:0] exp_ops, input bit exp_err,
                           input bit gaps);
        int s0, e0;
        s0 = n_start;
        e0 = n_err;
        bus.op_ready = (delay == 0);
        for (int i = 0; i < n; i++) begin
            send_word(wp[i*DATA_W +: DATA_W], (i == n - 1) && last, gaps);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({nm, "_full_ready"}, bus.in_ready, 0);
        check({nm, "_full_busy"}, bus.busy, 1);
        check({nm, "_ops"}, bus.ops, exp_ops);
        check({nm, "_start_early"}, bus.start, 0);
        if (delay == 0) begin
            step();
            check({nm, "_start_k1"}, bus.start, 1);
            step();
            check({nm, "_start_k2"}, bus.start, 0);
        end else begin
            for (int c = 0; c < delay; c++) begin
                bus.done_next = (c == 0);
                step();
            end
            bus.done_next = 1'b0;
            check({nm, "_wait_ready"}, bus.in_ready, 0);
            check({nm, "_wait_nostart"}, n_start - s0, 0);
            check({nm, "_spurious_cnt"}, bus.job_cnt, exp_jobs);
            bus.op_ready = 1'b1;
            step();
            check({nm, "_start_after_opr"}, bus.start, 1);
            step();
        end
        repeat ($urandom_range(0, 3)) step();
        check({nm, "_ops_held"}, bus.ops, exp_ops);
        check({nm, "_start_count"}, n_start - s0, 1);
        check({nm, "_err_count"}, n_err - e0, exp_err);
        bus.done_next = 1'b1;
        step();
        bus.done_next = 1'b0;
        exp_jobs = (exp_jobs + 1) % 65536;
        check({nm, "_job_cnt"}, bus.job_cnt, exp_jobs);
        check({nm, "_reopen"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [BANK_W-1:0] wp;
        int                n, s0, e0;
        bit                lst;

        tbl[0] = '{"normal", 8, 1'b1, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 0,
                   128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0};
        tbl[1] = '{"opr_wait", 8, 1'b1, 128'h0088_0077_0066_0055_0044_0033_0022_0011, 20,
                   128'h0088_0077_0066_0055_0044_0033_0022_0011, 1'b0};
        tbl[2] = '{"short", 3, 1'b1, 128'h0000_0000_0000_0000_0000_000C_000B_000A, 0,
                   128'h0000_0000_0000_0000_0000_000C_000B_000A, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.op_ready  = 1'b0;
        bus.done_next = 1'b0;
        repeat (2) step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ops", bus.ops, 0);
        check("rst_job_cnt", bus.job_cnt, 0);
        check("rst_start", bus.start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err_len, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", bus.in_ready, 1);

        // Directed table.
        for (int v = 0; v < 3; v++) begin
            run_job(tbl[v].name, tbl[v].n, tbl[v].last, tbl[v].words, tbl[v].delay,
                    tbl[v].exp_ops, tbl[v].exp_err, 1'b0);
        end

        // Reset while in RUN with three jobs completed.
        check("pre_rst_job_cnt", bus.job_cnt, 3);
        bus.op_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) send_word(16'h0F00 + 16'(i), i == NUM_IN - 1, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        step();
        check("run_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", bus.in_ready, 0);
        check("midrst_ops", bus.ops, 0);
        check("midrst_job_cnt", bus.job_cnt, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_start", bus.start, 0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_ready", bus.in_ready, 1);
        exp_jobs = 0;
        run_job("post_rst", 8, 1'b1, tbl[0].words, 0, tbl[0].exp_ops, 1'b0, 1'b0);

        // Spurious done_next while idle in LOAD.
        bus.done_next = 1'b1;
        step();
        bus.done_next = 1'b0;
        check("spur_load_cnt", bus.job_cnt, exp_jobs);
        check("spur_load_ready", bus.in_ready, 1);
        check("spur_load_busy", bus.busy, 0);

        // Long job: eight words, no in_last, valid kept high afterwards.
        s0 = n_start;
        e0 = n_err;
        bus.op_ready = 1'b1;
        wp = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wp[i*DATA_W +: DATA_W] = 16'h0100 + 16'(i);
            send_word(16'h0100 + 16'(i), 1'b0, 1'b0);
        end
        bus.in_data = 16'hDEAD;
        bus.in_last = 1'b1;
        check("long_ready_full", bus.in_ready, 0);
        repeat (6) step();
        check("long_ready_run", bus.in_ready, 0);
        check("long_ops", bus.ops, wp);
        check("long_err_count", n_err - e0, 1);
        check("long_start_count", n_start - s0, 1);
        bus.done_next = 1'b1;
        step();
        bus.done_next = 1'b0;
        exp_jobs++;
        check("long_job_cnt", bus.job_cnt, exp_jobs);
        check("long_reopen", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("ninth_word_slot0", bus.ops, 128'h0000_0000_0000_0000_0000_0000_0000_DEAD);
        check("ninth_word_full", bus.in_ready, 0);
        repeat (2) step();
        bus.done_next = 1'b1;
        step();
        bus.done_next = 1'b0;
        exp_jobs++;
        check("ninth_job_cnt", bus.job_cnt, exp_jobs);

        // Randomized jobs against the model.
        for (int j = 0; j < 25; j++) begin
            n   = $urandom_range(1, NUM_IN);
            lst = (n < NUM_IN) ? 1'b1 : 1'($urandom_range(0, 1));
            wp  = '0;
            for (int i = 0; i < NUM_IN; i++) wp[i*DATA_W +: DATA_W] = 16'($urandom);
            run_job("rand", n, lst, wp, $urandom_range(0, 3), model_ops(wp, n),
                    !(n == NUM_IN && lst), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
